// File: rtl/worddemux_pkg.sv
// rtl/worddemux_pkg.sv - shared types and constants for the worddemux4_stream word demultiplexer
package worddemux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int WIDTH_DEF = 16;
    localparam int COUNT_W   = 16;

endpackage

// File: rtl/word_skid.sv
// rtl/word_skid.sv - two-entry skid stage (output register + skid register) with registered upstream ready
module word_skid
    import worddemux_pkg::*;
#(
    parameter int PW = 19
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    output logic          o_ready,
    input  logic [PW-1:0] i_payload,
    output logic          o_valid,
    output logic [PW-1:0] o_payload,
    input  logic          i_fire
);

    skid_state_e   state_q, state_d;
    logic [PW-1:0] out_q, out_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          ready_q, ready_d;
    logic          accept;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        accept  = i_push & ready_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = i_payload;
                end
            end
            ST_ONE: begin
                if (accept && i_fire) begin
                    out_d = i_payload;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = i_payload;
                end else if (i_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Upstream is stalled here, so only a fire can move the stage.
                if (i_fire) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = (state_q != ST_EMPTY);
    assign o_payload = out_q;

endmodule

// File: rtl/worddemux4_stream.sv
// rtl/worddemux4_stream.sv - streaming one-to-N_DEST word demultiplexer; WORDDEMUX_BCAST_EN adds broadcast with done mask
module worddemux4_stream
    import worddemux_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int N_DEST = 4,
    parameter int SEL_W  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
`ifdef WORDDEMUX_BCAST_EN
    input  logic               i_bcast,
`endif
    input  logic [SEL_W-1:0]   i_sel,
    input  logic [WIDTH-1:0]   i_data,
    output logic [N_DEST-1:0]  o_valid,
    input  logic [N_DEST-1:0]  i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_drop,
    output logic [COUNT_W-1:0] o_count
);

    localparam int PW = WIDTH + SEL_W + 1;

    logic               in_bcast;
    logic               keep;
    logic               skid_ready;
    logic               skid_valid;
    logic               fire;
    logic [PW-1:0]      out_payload;
    logic               out_bcast;
    logic [SEL_W-1:0]   out_sel;
    logic [WIDTH-1:0]   out_data;
    logic [N_DEST-1:0]  sel_vec;
    logic [N_DEST-1:0]  valid_vec;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               drop_q, drop_d;

`ifdef WORDDEMUX_BCAST_EN
    assign in_bcast = i_bcast;
`else
    assign in_bcast = 1'b0;
`endif

    // Out-of-range words are still accepted upstream but never enter the skid stage.
    assign keep = in_bcast | (32'(i_sel) < N_DEST);

    word_skid #(
        .PW(PW)
    ) u_skid (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_push   (i_valid & keep),
        .o_ready  (skid_ready),
        .i_payload({in_bcast, i_sel, i_data}),
        .o_valid  (skid_valid),
        .o_payload(out_payload),
        .i_fire   (fire)
    );

    assign {out_bcast, out_sel, out_data} = out_payload;

    always_comb begin
        sel_vec = '0;
        for (int d = 0; d < N_DEST; d++) begin
            if (out_sel == SEL_W'(d)) sel_vec[d] = 1'b1;
        end
    end

`ifdef WORDDEMUX_BCAST_EN
    logic [N_DEST-1:0] done_q, done_d;
    logic [N_DEST-1:0] hs;

    always_comb begin
        valid_vec = '0;
        if (skid_valid) valid_vec = out_bcast ? ~done_q : sel_vec;
        hs     = valid_vec & i_ready;
        fire   = 1'b0;
        done_d = done_q;
        if (skid_valid && out_bcast) begin
            // A broadcast word retires only once every destination has taken it.
            if ((done_q | hs) == {N_DEST{1'b1}}) begin
                fire   = 1'b1;
                done_d = '0;
            end else begin
                done_d = done_q | hs;
            end
        end else begin
            fire = |hs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) done_q <= '0;
        else          done_q <= done_d;
    end
`else
    always_comb begin
        valid_vec = (skid_valid && !out_bcast) ? sel_vec : '0;
        fire      = |(valid_vec & i_ready);
    end
`endif

    always_comb begin
        count_d = count_q + (fire ? COUNT_W'(1) : COUNT_W'(0));
        drop_d  = i_valid & skid_ready & ~keep;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign o_ready = skid_ready;
    assign o_valid = valid_vec;
    assign o_data  = out_data;
    assign o_drop  = drop_q;
    assign o_count = count_q;

endmodule
